// File: rtl/multi_channel_delay_compensator_if.sv
// Stream and config bus of the multi-channel delay compensator.
// Master drives config writes, input samples and m_ready. Slave is the compensator.
interface multi_channel_delay_compensator_if #(
  parameter int unsigned CH_W = 2,
  parameter int unsigned TS_W = 64
);
  logic            cfg_valid;
  logic            cfg_ready;
  logic [CH_W-1:0] cfg_ch;
  logic [31:0]     cfg_delay;
  logic            cfg_enable;
  logic            s_valid;
  logic            s_ready;
  logic [CH_W-1:0] s_ch;
  logic [TS_W-1:0] s_time;
  logic            m_valid;
  logic            m_ready;
  logic [CH_W-1:0] m_ch;
  logic [TS_W-1:0] m_time;
  logic            m_comp;
  logic            m_underflow;

  modport master (
    output cfg_valid, cfg_ch, cfg_delay, cfg_enable, s_valid, s_ch, s_time, m_ready,
    input  cfg_ready, s_ready, m_valid, m_ch, m_time, m_comp, m_underflow
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_delay, cfg_enable, s_valid, s_ch, s_time, m_ready,
    output cfg_ready, s_ready, m_valid, m_ch, m_time, m_comp, m_underflow
  );
endinterface

// File: rtl/multi_channel_delay_compensator.sv
// Subtracts a per-channel, slew-limited propagation delay from ns timestamps.
// Delays are configured in ms (16.16) and converted to ns by a 3-stage pipeline.
module multi_channel_delay_compensator #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned TS_W    = 64,
  parameter int unsigned SLEW_NS = 1000
) (
  input  logic              clk,
  input  logic              rst,
  multi_channel_delay_compensator_if.slave bus,
  input  logic              slew_tick,
  input  logic [NUM_CH-1:0] underflow_clr,
  output logic [NUM_CH-1:0] ch_enabled,
  output logic [NUM_CH-1:0] ch_settled,
  output logic [NUM_CH-1:0] underflow_sticky
);
  localparam int unsigned PROD_W = 52;
  localparam int unsigned PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NUM_CH - 1);
  localparam logic [TS_W-1:0]  SLEW_STEP = TS_W'(SLEW_NS);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  logic              cfg_ready_q;
  logic              c1_valid, c1_en, c2_valid, c2_en;
  logic [CH_W-1:0]   c1_ch, c2_ch;
  logic [31:0]       c1_delay;
  logic [PROD_W-1:0] c2_prod;
  logic [TS_W-1:0]   c2_tgt;
  logic              c2_hit, c2_in_range, s_in_range;
  logic [PTR_W-1:0]  c2_idx, s_idx;

  logic [TS_W-1:0]   target   [NUM_CH];
  logic [TS_W-1:0]   applied  [NUM_CH];
  logic [TS_W-1:0]   target_n [NUM_CH];
  logic [TS_W-1:0]   applied_n[NUM_CH];
  logic [NUM_CH-1:0] enable_n, settled_n;
  logic [TS_W-1:0]   cur_tgt, cur_app, diff, step;

  logic [0:0]        state, state_n;
  logic [PTR_W-1:0]  ptr, ptr_n;

  logic              pipe_en, s1_valid, s1_en, s1_uf;
  logic [CH_W-1:0]   s1_ch;
  logic [TS_W-1:0]   s1_time, s1_app;

  assign bus.cfg_ready = cfg_ready_q;
  assign c2_idx        = PTR_W'(c2_ch);
  assign s_idx         = PTR_W'(bus.s_ch);
  assign c2_tgt        = TS_W'(c2_prod >> 16);
  assign c2_hit        = c2_valid && c2_in_range;

  // Channel indices beyond NUM_CH only exist when CH_W is wider than needed.
  if (NUM_CH < (2 ** CH_W)) begin : g_range
    assign c2_in_range = 32'(c2_ch) < NUM_CH;
    assign s_in_range  = 32'(bus.s_ch) < NUM_CH;
  end else begin : g_full
    assign c2_in_range = 1'b1;
    assign s_in_range  = 1'b1;
  end

  // Config pipeline: C0 accept, C1 multiply, C2 write back.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready_q <= 1'b1;
      c1_valid    <= 1'b0;
      c1_en       <= 1'b0;
      c1_ch       <= '0;
      c1_delay    <= '0;
      c2_valid    <= 1'b0;
      c2_en       <= 1'b0;
      c2_ch       <= '0;
      c2_prod     <= '0;
    end else begin
      c1_valid <= bus.cfg_valid && cfg_ready_q;
      c2_valid <= c1_valid;
      if (bus.cfg_valid && cfg_ready_q) begin
        cfg_ready_q <= 1'b0;
        c1_ch       <= bus.cfg_ch;
        c1_delay    <= bus.cfg_delay;
        c1_en       <= bus.cfg_enable;
      end
      if (c1_valid) begin
        c2_prod <= PROD_W'(c1_delay) * PROD_W'(1_000_000);
        c2_ch   <= c1_ch;
        c2_en   <= c1_en;
      end
      if (c2_valid) cfg_ready_q <= 1'b1;
    end
  end

  // Next delay state: slew step first, so a same-channel config write overrides it.
  always_comb begin
    target_n  = target;
    applied_n = applied;
    enable_n  = ch_enabled;
    cur_tgt   = target[ptr];
    cur_app   = applied[ptr];
    diff      = (cur_tgt >= cur_app) ? (cur_tgt - cur_app) : (cur_app - cur_tgt);
    step      = ((SLEW_NS == 0) || (diff < SLEW_STEP)) ? diff : SLEW_STEP;
    if ((state == ST_SWEEP) && ch_enabled[ptr])
      applied_n[ptr] = (cur_tgt >= cur_app) ? (cur_app + step) : (cur_app - step);
    if (c2_hit) begin
      target_n[c2_idx] = c2_tgt;
      enable_n[c2_idx] = c2_en;
      if (!c2_en)             applied_n[c2_idx] = '0;
      else if (SLEW_NS == 0)  applied_n[c2_idx] = c2_tgt;
      else                    applied_n[c2_idx] = applied[c2_idx];
    end
    for (int i = 0; i < NUM_CH; i++)
      settled_n[i] = !enable_n[i] || (applied_n[i] == target_n[i]);
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    case (state)
      ST_IDLE: begin
        if (slew_tick) begin
          state_n = ST_SWEEP;
          ptr_n   = '0;
        end
      end
      ST_SWEEP: begin
        if (ptr == LAST_PTR) begin
          state_n = ST_IDLE;
          ptr_n   = '0;
        end else begin
          ptr_n = ptr + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        ptr_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      ch_enabled <= '0;
      ch_settled <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        target[i]  <= '0;
        applied[i] <= '0;
      end
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      ch_enabled <= enable_n;
      ch_settled <= settled_n;
      target     <= target_n;
      applied    <= applied_n;
    end
  end

  // Two-stage datapath; both stages move together so stalled bubbles stay in place.
  assign pipe_en     = !bus.m_valid || bus.m_ready;
  assign bus.s_ready = pipe_en;
  assign s1_uf       = s1_en && (s1_time < s1_app);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid        <= 1'b0;
      s1_en           <= 1'b0;
      s1_ch           <= '0;
      s1_time         <= '0;
      s1_app          <= '0;
      bus.m_valid     <= 1'b0;
      bus.m_ch        <= '0;
      bus.m_time      <= '0;
      bus.m_comp      <= 1'b0;
      bus.m_underflow <= 1'b0;
    end else if (pipe_en) begin
      s1_valid        <= bus.s_valid;
      s1_ch           <= bus.s_ch;
      s1_time         <= bus.s_time;
      s1_en           <= s_in_range && ch_enabled[s_idx];
      s1_app          <= s_in_range ? applied[s_idx] : '0;
      bus.m_valid     <= s1_valid;
      bus.m_ch        <= s1_ch;
      bus.m_comp      <= s1_en;
      bus.m_underflow <= s1_uf;
      bus.m_time      <= !s1_en ? s1_time : (s1_uf ? '0 : (s1_time - s1_app));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_sticky <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.m_valid && bus.m_ready && bus.m_underflow && (bus.m_ch == CH_W'(i)))
          underflow_sticky[i] <= 1'b1;
        else if (underflow_clr[i])
          underflow_sticky[i] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_multi_channel_delay_compensator.sv
// Scoreboard bench: one instance with immediate delay application, one with slew limiting.
// A select signal routes the shared stimulus to one instance at a time.
module tb_multi_channel_delay_compensator;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned TS_W   = 64;
  localparam logic [31:0]     D120 = 32'h0078_0000;
  localparam logic [TS_W-1:0] T0   = 64'd1_000_000_000;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [TS_W-1:0] t;
    logic            comp;
    logic            uf;
  } exp_t;

  logic clk, rst, sel;
  logic cfg_valid, cfg_enable, s_valid, m_ready, slew_tick;
  logic [CH_W-1:0] cfg_ch, s_ch;
  logic [31:0] cfg_delay;
  logic [TS_W-1:0] s_time;
  logic [NUM_CH-1:0] underflow_clr;

  logic cfg_ready, s_ready, m_valid, m_comp, m_underflow;
  logic [CH_W-1:0] m_ch;
  logic [TS_W-1:0] m_time;
  logic [NUM_CH-1:0] ch_enabled, ch_settled, underflow_sticky;
  logic [NUM_CH-1:0] en_imm, set_imm, uf_imm, en_slw, set_slw, uf_slw;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [TS_W-1:0] snap_t;
  logic [CH_W-1:0] snap_ch;

  multi_channel_delay_compensator_if #(.CH_W(CH_W), .TS_W(TS_W)) bus_imm ();
  multi_channel_delay_compensator_if #(.CH_W(CH_W), .TS_W(TS_W)) bus_slw ();

  assign bus_imm.cfg_valid  = cfg_valid & ~sel;
  assign bus_imm.cfg_ch     = cfg_ch;
  assign bus_imm.cfg_delay  = cfg_delay;
  assign bus_imm.cfg_enable = cfg_enable;
  assign bus_imm.s_valid    = s_valid & ~sel;
  assign bus_imm.s_ch       = s_ch;
  assign bus_imm.s_time     = s_time;
  assign bus_imm.m_ready    = m_ready | sel;
  assign bus_slw.cfg_valid  = cfg_valid & sel;
  assign bus_slw.cfg_ch     = cfg_ch;
  assign bus_slw.cfg_delay  = cfg_delay;
  assign bus_slw.cfg_enable = cfg_enable;
  assign bus_slw.s_valid    = s_valid & sel;
  assign bus_slw.s_ch       = s_ch;
  assign bus_slw.s_time     = s_time;
  assign bus_slw.m_ready    = m_ready | ~sel;

  assign cfg_ready        = sel ? bus_slw.cfg_ready   : bus_imm.cfg_ready;
  assign s_ready          = sel ? bus_slw.s_ready     : bus_imm.s_ready;
  assign m_valid          = sel ? bus_slw.m_valid     : bus_imm.m_valid;
  assign m_ch             = sel ? bus_slw.m_ch        : bus_imm.m_ch;
  assign m_time           = sel ? bus_slw.m_time      : bus_imm.m_time;
  assign m_comp           = sel ? bus_slw.m_comp      : bus_imm.m_comp;
  assign m_underflow      = sel ? bus_slw.m_underflow : bus_imm.m_underflow;
  assign ch_enabled       = sel ? en_slw  : en_imm;
  assign ch_settled       = sel ? set_slw : set_imm;
  assign underflow_sticky = sel ? uf_slw  : uf_imm;

  multi_channel_delay_compensator #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .TS_W(TS_W), .SLEW_NS(0)
  ) u_imm (
    .clk(clk), .rst(rst), .bus(bus_imm),
    .slew_tick(slew_tick & ~sel),
    .underflow_clr(underflow_clr & {NUM_CH{~sel}}),
    .ch_enabled(en_imm), .ch_settled(set_imm), .underflow_sticky(uf_imm)
  );

  multi_channel_delay_compensator #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .TS_W(TS_W), .SLEW_NS(50_000_000)
  ) u_slw (
    .clk(clk), .rst(rst), .bus(bus_slw),
    .slew_tick(slew_tick & sel),
    .underflow_clr(underflow_clr & {NUM_CH{sel}}),
    .ch_enabled(en_slw), .ch_settled(set_slw), .underflow_sticky(uf_slw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [31:0] d, input logic en);
    int n;
    cfg_valid = 1'b1; cfg_ch = ch; cfg_delay = d; cfg_enable = en;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 50) begin @(negedge clk); n++; end
    check("cfg_accept", 64'(cfg_ready), 64'd1);
    tick();
    cfg_valid = 1'b0;
    @(negedge clk);
    check("cfg_busy", 64'(cfg_ready), 64'd0);
    n = 0;
    while (!cfg_ready && n < 50) begin @(negedge clk); n++; end
    check("cfg_turnaround", 64'(n), 64'd2);
    tick();
  endtask

  task automatic send(input logic [CH_W-1:0] ch, input logic [TS_W-1:0] t,
                      input logic [TS_W-1:0] et, input logic ec, input logic eu);
    int n;
    exp_t e;
    s_valid = 1'b1; s_ch = ch; s_time = t;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    check("send_accept", 64'(s_ready), 64'd1);
    e.ch = ch; e.t = et; e.comp = ec; e.uf = eu;
    sb.push_back(e);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("drain", 64'(sb.size()), 64'd0);
    tick();
  endtask

  task automatic sweep(input bit mid_tick);
    slew_tick = 1'b1;
    tick();
    slew_tick = 1'b0;
    if (mid_tick) begin
      tick();
      slew_tick = 1'b1;
      tick();
      slew_tick = 1'b0;
    end
    repeat (8) tick();
  endtask

  // Output-side scoreboard: every handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("out_ch",   64'(m_ch),        64'(mon_e.ch));
        check("out_time", m_time,           mon_e.t);
        check("out_comp", 64'(m_comp),      64'(mon_e.comp));
        check("out_uf",   64'(m_underflow), 64'(mon_e.uf));
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; m_ready = 1'b1; slew_tick = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_delay = '0; cfg_enable = 1'b0;
    s_valid = 1'b0; s_ch = '0; s_time = '0; underflow_clr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid",  64'(m_valid),          64'd0);
    check("rst_m_time",   m_time,                64'd0);
    check("rst_cfg_rdy",  64'(cfg_ready),        64'd1);
    check("rst_s_ready",  64'(s_ready),          64'd1);
    check("rst_enabled",  64'(ch_enabled),       64'd0);
    check("rst_settled",  64'(ch_settled),       64'hF);
    check("rst_sticky",   64'(underflow_sticky), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Immediate config: 120 ms applied at once, 2-cycle latency.
    cfg_write(2'd0, D120, 1'b1);
    check("imm_enabled", 64'(ch_enabled), 64'b0001);
    check("imm_settled", 64'(ch_settled), 64'hF);
    send(2'd0, T0, 64'd880_000_000, 1'b1, 1'b0);
    @(negedge clk);
    check("lat_cycle1", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2", 64'(m_valid), 64'd1);
    wait_drain();

    // Fractional ms: 1 LSB is 15.258 ns, floored to 15.
    cfg_write(2'd1, 32'h0000_0001, 1'b1);
    send(2'd1, 64'd100, 64'd85, 1'b1, 1'b0);
    wait_drain();

    // Underflow saturates and sets the sticky flag; clear pulse removes it.
    cfg_write(2'd1, D120, 1'b1);
    send(2'd1, 64'd100_000_000, 64'd0, 1'b1, 1'b1);
    wait_drain();
    check("sticky_set", 64'(underflow_sticky), 64'b0010);
    underflow_clr = 4'b0010;
    tick();
    underflow_clr = '0;
    check("sticky_clr", 64'(underflow_sticky), 64'd0);

    // Unconfigured channel passes through.
    send(2'd2, 64'd12345, 64'd12345, 1'b0, 1'b0);
    wait_drain();

    // Backpressure: 6 samples with a 5-cycle stall in the middle.
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(2'd0, T0 + 64'(i), T0 + 64'(i) - 64'd120_000_000, 1'b1, 1'b0);
      end
      begin
        repeat (3) tick();
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_valid",   64'(m_valid), 64'd1);
          check("stall_s_ready", 64'(s_ready), 64'd0);
          if (k == 0) begin
            snap_t  = m_time;
            snap_ch = m_ch;
          end else begin
            check("stall_time", m_time,     snap_t);
            check("stall_ch",   64'(m_ch),  64'(snap_ch));
          end
        end
        tick();
        m_ready = 1'b1;
      end
    join
    wait_drain();

    // Slew-limited instance: ramp ch2 to 120 ms in 50 ms steps.
    sel = 1'b1;
    tick();
    cfg_write(2'd2, D120, 1'b1);
    check("slw_enabled", 64'(ch_enabled), 64'b0100);
    check("slw_settled0", 64'(ch_settled), 64'b1011);
    send(2'd2, T0, T0, 1'b1, 1'b0);
    wait_drain();
    sweep(1'b0);
    send(2'd2, T0, 64'd950_000_000, 1'b1, 1'b0);
    wait_drain();
    check("slw_settled1", 64'(ch_settled), 64'b1011);
    sweep(1'b1);
    send(2'd2, T0, 64'd900_000_000, 1'b1, 1'b0);
    wait_drain();
    check("slw_settled2", 64'(ch_settled), 64'b1011);
    sweep(1'b0);
    send(2'd2, T0, 64'd880_000_000, 1'b1, 1'b0);
    wait_drain();
    check("slw_settled3", 64'(ch_settled), 64'hF);

    // ch0 ramps to 50 ms, then a rewrite collides with its slew update.
    cfg_write(2'd0, D120, 1'b1);
    sweep(1'b0);
    send(2'd0, T0, 64'd950_000_000, 1'b1, 1'b0);
    wait_drain();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_delay = D120; cfg_enable = 1'b1;
    @(negedge clk);
    check("coll_cfg_rdy", 64'(cfg_ready), 64'd1);
    tick();
    cfg_valid = 1'b0;
    slew_tick = 1'b1;
    tick();
    slew_tick = 1'b0;
    repeat (8) tick();
    check("coll_settled", 64'(ch_settled), 64'b1110);
    send(2'd0, T0, 64'd950_000_000, 1'b1, 1'b0);
    wait_drain();

    // Disable mid-ramp forces pass-through; re-enable ramps from zero.
    cfg_write(2'd0, D120, 1'b0);
    check("dis_enabled", 64'(ch_enabled), 64'b0100);
    check("dis_settled", 64'(ch_settled), 64'hF);
    send(2'd0, T0, T0, 1'b0, 1'b0);
    wait_drain();
    cfg_write(2'd0, D120, 1'b1);
    send(2'd0, T0, T0, 1'b1, 1'b0);
    wait_drain();
    sweep(1'b0);
    send(2'd0, T0, 64'd950_000_000, 1'b1, 1'b0);
    wait_drain();
    check("sb_final", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_channel_delay_compensator.md
# multi_channel_delay_compensator

Parametrised, multi-channel successor to single-channel satellite propagation-delay compensation. It subtracts a per-channel delay from nanosecond timestamps on a valid/ready stream. Each delay is configured in milliseconds (16.16) and converted to ns by a registered pipeline. The applied delay slews toward its target in bounded steps, so PPS/time outputs never jump. It sits between the T2-MI timestamp extractor and the PPS/time-of-day generators, and serves up to NUM_CH satellite/receiver inputs.

## Interface
- NUM_CH, 4: number of channels (1..16).
- CH_W, 2: channel index width, ≥ clog2(NUM_CH).
- TS_W, 64: timestamp width in ns.
- SLEW_NS, 1000: maximum change of applied delay per slew sweep, in ns; 0 means the target is applied immediately.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config port idle; a write is accepted when cfg_valid && cfg_ready.
- cfg_ch  in  CH_W  channel to configure.
- cfg_delay  in  32  delay in ms, unsigned 16.16.
- cfg_enable  in  1  compensation enable for cfg_ch.
- slew_tick  in  1  single-cycle pulse that starts one slew sweep.
- s_valid / s_ready  in / out  1  input timestamp handshake.
- s_ch  in  CH_W  input channel.
- s_time  in  TS_W  input timestamp in ns.
- m_valid / m_ready  out / in  1  output handshake.
- m_ch  out  CH_W  channel of the output sample.
- m_time  out  TS_W  compensated timestamp.
- m_comp  out  1  compensation was applied to this sample.
- m_underflow  out  1  result saturated to 0.
- ch_enabled  out  NUM_CH  per-channel enable.
- ch_settled  out  NUM_CH  per-channel: applied delay equals target, or the channel is disabled.
- underflow_sticky  out  NUM_CH  per-channel sticky underflow flag.
- underflow_clr  in  NUM_CH  per-bit clear of underflow_sticky.

## Operation
- **Config pipeline.**
  - C0: write accepted; cfg_ready goes low.
  - C1: product = cfg_delay × 1_000_000 (52 bits, unsigned) is registered.
  - C2: target[ch] = product >> 16 (floor), zero-extended to TS_W, and enable[ch] = cfg_enable are written. cfg_ready returns high in the following cycle.
  - Any cfg_ch ≥ NUM_CH is accepted and discarded.
- **Enable transitions** at C2:
  - 1→0: applied[ch] is forced to 0 and the channel passes through.
  - 0→1: applied[ch] starts from 0 and ramps to the target.
  - If SLEW_NS == 0, C2 also sets applied[ch] = enabled ? target : 0.
- **Slew engine**, FSM IDLE → SWEEP → IDLE.
  - A slew_tick in IDLE starts SWEEP with ptr = 0.
  - Each SWEEP cycle updates channel ptr, then ptr increments. SWEEP ends after channel NUM_CH-1 (NUM_CH cycles).
  - Update rule for an enabled channel: diff = |target − applied|; applied moves toward target by min(diff, SLEW_NS).
  - Disabled channels are left at 0.
  - slew_tick received during SWEEP is ignored.
- **Collision:** if a C2 write and the slew update hit the same channel in the same cycle, the C2 write wins and that slew update is dropped.
- **Datapath**, a two-stage pipeline.
  - S1 registers s_time and s_ch, and samples applied[s_ch] and enable[s_ch] at the acceptance cycle.
  - S2 computes:
    - enabled: m_time = s_time − applied, saturated to 0. m_underflow = 1 when s_time < applied.
    - disabled: m_time = s_time, m_comp = 0.
    - m_comp = enable.
  - pipe_en = !m_valid || m_ready; s_ready = pipe_en. Both stages advance only on pipe_en.
  - Bubbles are not collapsed inside a stalled pipe.
  - When m_valid is low, m_* payload is don't-care.
- **Sticky flags:** underflow_sticky[ch] sets on an output handshake with m_underflow. underflow_clr clears the bit. If clear and set occur in the same cycle, set wins.

## Timing
- **Reset (rst high at a clk edge):** all outputs take their reset values on that edge:
  - m_valid = 0, m_time = 0, m_ch = 0, m_comp = 0, m_underflow = 0.
  - ch_enabled = 0, ch_settled = all 1, underflow_sticky = 0.
  - cfg_ready = 1, s_ready = 1.
  - target = 0, applied = 0, FSM = IDLE.
- Reset mid-sweep or mid-config aborts the operation; the pending write is lost.
- **Datapath latency:** 2 cycles from s_valid && s_ready to m_valid, with m_ready held high. Throughput is 1 sample per cycle.
- **Stall:** m_ready low while m_valid is high holds all m_* outputs stable and drops s_ready in the same cycle.
- **Config:** a write is visible to samples accepted from C3 onward. Back-to-back writes are possible every 3 cycles.
- **Slew:** a slew_tick at cycle T updates channel k at cycle T+1+k.

## Test plan
- **Immediate config:** SLEW_NS = 0; write ch0 with cfg_delay = 0x0078_0000 (120.0 ms) and enable = 1; then s_time = 1_000_000_000 → m_time = 880_000_000, m_comp = 1, with 2-cycle latency.
- **Fractional conversion:** cfg_delay = 0x0000_0001 → target 15 ns. Input 100 → output 85.
- **Slew ramp:** SLEW_NS = 50_000_000; enable ch2 at 120 ms. Successive sweeps → applied = 50M, 100M, 120M. ch_settled[2] rises after the third sweep. A tick issued mid-sweep is ignored.
- **Underflow:** ch1 at 120 ms with s_time = 100_000_000 → m_time = 0, m_underflow = 1, underflow_sticky[1] = 1. Pulsing underflow_clr[1] clears it.
- **Backpressure:** stream 6 samples with m_ready low for 5 cycles mid-stream → no loss or duplication, order preserved, and m_* stable during the stall.
- **Disable and collision:**
  - Disabling ch0 mid-ramp → pass-through on the next accepted sample, and applied is 0.
  - Re-enabling ramps from 0.
  - A C2 write colliding with the sweep on the same channel → the written value wins.
